regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port controller for the 32 x 32-bit register file. It owns the file's single write port (A3/WD3/RegWEn) and arbitrates it round-robin between two writeback requesters over valid/ready handshakes. It also runs a clear sequence that zeroes registers 1..31 after reset or on request. It sits between the writeback stage (ALU result and load/multi-cycle result) and the register file write inputs; read ports A1/A2 are not touched.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers; clear sequence covers 1..NREGS-1
- clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- init_req  in  1  synchronous request to re-run the clear sequence (pulse, sampled in RUN only)
- req0_valid  in  1  source 0 (ALU) write request
- req0_addr  in  ADDR_W  source 0 destination register
- req0_data  in  DATA_W  source 0 write data
- req0_ready  out  1  source 0 accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data  in  1 / ADDR_W / DATA_W  source 1 (load/multi-cycle) request
- req1_ready  out  1  source 1 accepted this cycle (combinational)
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)
- RegWEn  out  1  register file write enable (registered)
- grant_id  out  1  source of the write currently on A3/WD3 (registered)
- init_busy  out  1  high while the clear sequence runs (registered)

## Operation
- States: INIT (clearing), RUN.
- Reset (async): state=INIT, clear counter=1, priority pointer=0, A3=0, WD3=0, RegWEn=0, grant_id=0, init_busy=1. req0_ready=req1_ready=0 while in INIT.
- INIT: each cycle, register A3=counter, WD3=0, RegWEn=1, then increment the counter. After issuing counter=NREGS-1, go to RUN and drop init_busy on the same edge. Register 0 is never written. Requests are held off (ready=0).
- RUN arbitration, combinational from valid and pointer:
  - Only one source valid: grant it.
  - Both valid: grant the source equal to the pointer.
  - Neither valid: no grant.
- Pointer: on every grant, pointer <= ~granted source. Round-robin fairness holds even without contention.
- Accepted request (valid & ready at an edge): next cycle A3=addr, WD3=data, grant_id=source, RegWEn=1. If addr==0, the request is still accepted and the pointer still updates, but RegWEn=0 (write to x0 discarded).
- No grant: RegWEn=0 next cycle; A3/WD3/grant_id hold their previous values.
- init_req high in RUN: no grant that cycle (both ready=0), counter<=1, state<=INIT, init_busy<=1, RegWEn<=0 next cycle. init_req is ignored in INIT.
- Both sources targeting the same register: writes are serialized in grant order, so the later grant's data ends up in the register file.

## Timing
- Request accepted at edge N: A3/WD3/RegWEn valid from N to N+1; register file commits at edge N+1. Data is readable via RD1/RD2 after N+1.
- Throughput: one write per cycle; contending sources alternate every cycle.
- Clear sequence: first clear write is presented on the first edge after Reset deasserts. It occupies NREGS-1 = 31 consecutive cycles of RegWEn=1. init_busy falls on the edge that presents the write to register 31.
- Reset asserted mid-INIT or mid-RUN: outputs go to reset values immediately and asynchronously. Any in-flight presented write is lost. The clear sequence restarts at register 1.
- A requester must hold valid/addr/data stable until ready; the block does not buffer.

## Test plan
- Reset, then release: RegWEn=1 for 31 cycles with A3=1..31 and WD3=0, init_busy=1 throughout, both ready=0 → init_busy=0 after A3=31; then RD1 of any register reads 0.
- RUN, req0 only, addr=5, data=8 → req0_ready=1; next cycle A3=5, WD3=8, RegWEn=1, grant_id=0; register 5 reads 8 one cycle later.
- Both valid every cycle, req0 (addr=15, data=1984) and req1 (addr=17, data=42), pointer=0 → grants alternate 0,1,0,1; A3 sequence 15,17,15,17.
- req1 addr=0, data=0xFFFFFFFF → req1_ready=1, RegWEn=0 next cycle, register 0 stays 0, pointer flips to 0.
- Both sources target addr=23 (req0 data=1, req1 data=2), pointer=1 → req1 is written first, then req0; register 23 ends at 1.
- init_req pulsed together with req0_valid in RUN, then Reset asserted at clear step 10 → no grant that cycle and init_busy=1; after Reset, the clear sequence restarts at A3=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-port owner; clears x1..x31 after reset, then
//            round-robin arbitrates two writeback sources onto A3/WD3/RegWEn.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              init_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              RegWEn,
    output logic              grant_id,
    output logic              init_busy
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(NREGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ptr;

    logic              w_run;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_src;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // A pending init_req blocks grants in the same cycle it is seen.
    assign w_run  = (r_state == ST_RUN) && !init_req;
    assign w_gnt0 = w_run && req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1 = w_run && req1_valid && (!req0_valid ||  r_ptr);
    assign w_src  = w_gnt1;
    assign w_addr = w_src ? req1_addr : req0_addr;
    assign w_data = w_src ? req1_data : req0_data;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_INIT;
            r_cnt     <= C_FIRST;
            r_ptr     <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
            RegWEn    <= 1'b0;
            grant_id  <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    A3     <= r_cnt;
                    WD3    <= '0;
                    RegWEn <= 1'b1;
                    r_cnt  <= r_cnt + ADDR_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_state   <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    if (init_req) begin
                        r_state   <= ST_INIT;
                        r_cnt     <= C_FIRST;
                        init_busy <= 1'b1;
                        RegWEn    <= 1'b0;
                    end else if (w_gnt0 || w_gnt1) begin
                        A3       <= w_addr;
                        WD3      <= w_data;
                        grant_id <= w_src;
                        // Writes to x0 still consume the grant but never reach the file.
                        RegWEn   <= (w_addr != '0);
                        r_ptr    <= ~w_src;
                    end else begin
                        RegWEn <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
